// File: rtl/l1_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_cache_pkg
// Description : Shared types, widths and width helpers for the L1 data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_cache_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic int f_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int f_tag_w(input int addr_w, input int sets);
        return addr_w - 2 - $clog2(sets);
    endfunction

    // A direct-mapped cache still carries a 1-bit way index.
    function automatic int f_lru_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_lru_age.sv
`default_nettype none
// ============================================================================
// Module      : l1_lru_age
// Description : True-LRU age tracker for one cache set (age 0 = most recent).
// Revision    : 1.0 - initial release
// ============================================================================
module l1_lru_age
    import l1_cache_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int LRU_W = f_lru_w(WAYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    touch,
    input  logic [LRU_W-1:0]        touch_way,
    output logic [LRU_W-1:0]        victim_age_way,
    output logic [WAYS*LRU_W-1:0]   ages
);

    generate
        if (WAYS == 1) begin : g_direct
            assign victim_age_way = '0;
            assign ages           = '0;
        end else begin : g_lru
            logic [LRU_W-1:0] r_age [WAYS];
            logic [LRU_W-1:0] w_victim;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int w = 0; w < WAYS; w++) begin
                        r_age[w] <= LRU_W'(w);
                    end
                end else if (touch) begin
                    // Only ways more recent than the touched one age by one.
                    for (int w = 0; w < WAYS; w++) begin
                        if (LRU_W'(w) == touch_way) begin
                            r_age[w] <= '0;
                        end else if (r_age[w] < r_age[touch_way]) begin
                            r_age[w] <= r_age[w] + LRU_W'(1);
                        end
                    end
                end
            end

            always_comb begin
                w_victim = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (r_age[w] == LRU_W'(WAYS - 1)) begin
                        w_victim = LRU_W'(w);
                    end
                end
            end

            assign victim_age_way = w_victim;

            for (genvar w = 0; w < WAYS; w++) begin : g_pack
                assign ages[w*LRU_W +: LRU_W] = r_age[w];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/l1_nway_cache.sv
`default_nettype none
// ============================================================================
// Module      : l1_nway_cache
// Description : N-way set-associative write-back/write-allocate L1 D-cache.
//               Define L1_PERF_CNT_EN to add access/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_nway_cache
    import l1_cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 4,
    parameter int ADDR_W = 30
) (
    input  logic                clk,
    input  logic                proc_reset_n,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic                proc_stall,
    output logic [WORD_W-1:0]   proc_rdata,
    input  logic                stall,
    output logic                read,
    output logic                write,
    output logic [ADDR_W-1:0]   addr,
    output logic [BLOCK_W-1:0]  wdata,
    input  logic [BLOCK_W-1:0]  rdata,
    input  logic                ready
`ifdef L1_PERF_CNT_EN
    ,
    output logic [31:0]         access_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int IDX_W = f_idx_w(SETS);
    localparam int TAG_W = f_tag_w(ADDR_W, SETS);
    localparam int LRU_W = f_lru_w(WAYS);

    logic [BLOCK_W-1:0] r_data  [SETS][WAYS];
    logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
    logic [WAYS-1:0]    r_valid [SETS];
    logic [WAYS-1:0]    r_dirty [SETS];

    state_e             r_state;
    logic [LRU_W-1:0]   r_victim;
    logic               r_read;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [BLOCK_W-1:0] r_wdata;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [6:0]         w_word_lsb;
    logic               w_req;
    logic               w_is_write;
    logic               w_hit;
    logic [LRU_W-1:0]   w_hit_way;
    logic [LRU_W-1:0]   w_victim;
    logic               w_rst;
    logic [LRU_W-1:0]   w_lru_victim [SETS];
    logic [WAYS*LRU_W-1:0] w_ages    [SETS];

    assign w_idx      = proc_addr[IDX_W+1:2];
    assign w_tag      = proc_addr[ADDR_W-1:IDX_W+2];
    assign w_word_lsb = {proc_addr[1:0], 5'd0};
    assign w_req      = proc_read | proc_write;
    assign w_is_write = proc_write & ~proc_read;
    assign w_rst      = ~proc_reset_n;

    generate
        for (genvar s = 0; s < SETS; s++) begin : g_set_lru
            logic w_touch;
            assign w_touch = ~stall && (r_state == COMPARE) && w_req && w_hit
                             && (w_idx == IDX_W'(s));
            l1_lru_age #(
                .WAYS           (WAYS)
            ) u_lru (
                .clk            (clk),
                .rst            (w_rst),
                .touch          (w_touch),
                .touch_way      (w_hit_way),
                .victim_age_way (w_lru_victim[s]),
                .ages           (w_ages[s])
            );
        end
    endgenerate

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = LRU_W'(w);
            end
        end
        // Invalid ways are filled lowest-index first before LRU eviction kicks in.
        w_victim = w_lru_victim[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim = LRU_W'(w);
            end
        end
    end

    assign proc_stall = stall | (w_req & ~((r_state == COMPARE) & w_hit));
    assign proc_rdata = w_hit ? r_data[w_idx][w_hit_way][w_word_lsb +: WORD_W] : '0;

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_state  <= COMPARE;
            r_victim <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (!stall) begin
            case (r_state)
                COMPARE: begin
                    if (w_req && w_hit) begin
                        if (w_is_write) begin
                            r_data[w_idx][w_hit_way][w_word_lsb +: WORD_W] <= proc_wdata;
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end
                    end else if (w_req) begin
                        r_victim <= w_victim;
                        if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                            r_write <= 1'b1;
                            r_addr  <= {r_tag[w_idx][w_victim], w_idx, 2'b00};
                            r_wdata <= r_data[w_idx][w_victim];
                            r_state <= WRITEBACK;
                        end else begin
                            r_read  <= 1'b1;
                            r_addr  <= {w_tag, w_idx, 2'b00};
                            r_state <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (ready) begin
                        r_write <= 1'b0;
                        r_read  <= 1'b1;
                        r_addr  <= {w_tag, w_idx, 2'b00};
                        r_state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (ready) begin
                        r_data[w_idx][r_victim]  <= rdata;
                        r_tag[w_idx][r_victim]   <= w_tag;
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_read                   <= 1'b0;
                        r_state                  <= COMPARE;
                    end
                end
                default: r_state <= COMPARE;
            endcase
        end
    end

    assign read  = r_read;
    assign write = r_write;
    assign addr  = r_addr;
    assign wdata = r_wdata;

`ifdef L1_PERF_CNT_EN
    logic [31:0] r_access_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_access_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (!stall && (r_state == COMPARE) && w_req) begin
            if (w_hit) begin
                if (r_access_cnt != 32'hFFFF_FFFF) begin
                    r_access_cnt <= r_access_cnt + 32'd1;
                end
            end else if (r_miss_cnt != 32'hFFFF_FFFF) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign access_cnt = r_access_cnt;
    assign miss_cnt   = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/l1_nway_cache.md
Name: l1_nway_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate L1 data cache. It sits between the pipeline memory stage and the L2 cache.
- Successor to the fixed 2-way/4-set L1: way count and set count are generic, and replacement is true LRU instead of a fixed way preference.
- Hits complete in the request cycle.
- Misses write back a dirty victim, then refill a 128-bit block from L2.

Parameters:
WAYS, 4, associativity; power of 2, range 1..8
SETS, 4, sets per way; power of 2, range 2..64
ADDR_W, 30, processor word-address width
(derived) IDX_W = log2(SETS); TAG_W = ADDR_W-2-IDX_W; LRU_W = max(1, log2(WAYS))

Ports:
clk  in  1  clock, rising edge
proc_reset_n  in  1  synchronous active-low reset
proc_read  in  1  load request
proc_write  in  1  store request
proc_addr  in  ADDR_W  word address; [1:0]=word in block, [IDX_W+1:2]=set, upper bits=tag
proc_wdata  in  32  store data
proc_stall  out  1  request not complete this cycle
proc_rdata  out  32  load data, valid when request and !proc_stall
stall  in  1  L2 global busy; freezes this block
read  out  1  L2 block read request
write  out  1  L2 block write request
addr  out  ADDR_W  L2 block address, low 2 bits always 0
wdata  out  128  victim block for write
rdata  in  128  refill block
ready  in  1  L2 transfer done, one-cycle pulse

Behaviour:
- Reset (proc_reset_n=0 at clk edge):
  - all valid and dirty bits cleared; state=COMPARE.
  - read=write=0, addr=0, wdata=0.
  - LRU age of way w in each set = w.
  - Reset mid-transfer aborts: read/write low at the next edge; a late ready is ignored.
- Request: req = proc_read|proc_write. If both are high, the request is treated as a read.
- Combinational outputs:
  - proc_stall = req && !(state==COMPARE && hit).
  - proc_rdata = selected word of the hit way, else 0.
- COMPARE:
  - No req: hold.
  - Hit read: data returns with no added latency.
  - Hit write: update the word, set dirty at the edge.
  - Either hit: accessed way age=0; ways younger than its old age increment.
  - Miss, victim clean or invalid: go to ALLOCATE; register read=1, addr={tag,idx,2'b00}.
  - Miss, victim valid and dirty: go to WRITEBACK; register write=1, addr={victim tag,idx,2'b00}, wdata=victim block.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- The victim index is latched on the miss and held until the refill completes.
- WRITEBACK:
  - read/write/addr/wdata held.
  - On ready: write=0, read=1, addr=request block; go to ALLOCATE.
- ALLOCATE:
  - On ready: victim way gets data=rdata, tag, valid=1, dirty=0; read=0; go to COMPARE.
  - The next cycle rehits, so miss latency = L2 latency + 1 (clean victim) or + 2×L2 latency + 1 (dirty victim).
  - The refill itself does not touch LRU; the rehit in COMPARE does.
- stall=1 overrides everything:
  - state, arrays, LRU and all registered L2 outputs hold.
  - proc_stall is forced to 1.
  - ready is ignored while stall=1.
- proc_addr and request signals must remain stable while proc_stall=1; the cache does not re-sample them.
- WAYS=1 degenerates to direct-mapped: victim is way 0 and LRU logic is constant.

Optional Feature:
L1_PERF_CNT_EN:
- When defined, adds outputs access_cnt[31:0] and miss_cnt[31:0].
- access_cnt +1 on each completed request.
- miss_cnt +1 on each COMPARE→WRITEBACK or COMPARE→ALLOCATE transition.
- Both counters are frozen by stall, saturate at 0xFFFFFFFF, and clear on reset.
- Without the macro: no counter flops and no such ports.

Decomposition:
- Package l1_cache_pkg holds:
  - state enum {COMPARE, WRITEBACK, ALLOCATE}
  - BLOCK_W=128, WORD_W=32
  - derived-width helper functions
- Sub-module l1_lru_age: one per set, parametrised WAYS. Interface:
  - inputs touch (1), touch_way
  - outputs victim_age_way, ages
- The top instantiates SETS copies via generate.

Test Plan:
- Read 0x000 after reset → miss, read=1 with addr=0x000; L2 returns 128'h4_3_2_1 (32-bit words) after 3 cycles → proc_rdata=1, stall released the cycle after ready; re-read 0x001 → 2 with no stall.
- Write 0xDEAD to 0x010 (set 0 tag 1) after fill, then read → 0xDEAD in zero cycles, dirty set.
- Fill set 0 with tags 0,1,2,3 (0x00,0x10,0x20,0x30), touch 0x00, then read 0x40 → victim is tag 1 way; if it is dirty, write=1, addr=0x010 precedes read addr=0x040.
- Assert stall for 5 cycles during ALLOCATE with ready pulsed inside the window → ready is ignored, state frozen; second ready after stall drops completes the fill.
- Drop proc_reset_n during WRITEBACK → read=write=0 next cycle; reading 0x000 misses.
- With L1_PERF_CNT_EN: 10 accesses with 3 misses → access_cnt=10, miss_cnt=3.
